// File: rtl/alu_pipe_param.sv
// alu_pipe_param: parametrised, handshaked single-stage ALU.
//
// Sits between operand fetch and writeback. One operation is accepted per cycle when
// in_valid && in_ready; its result and flags land in a one-entry output register.
// Add-type ops share one carry-select adder. A persistent carry register chains multi-word
// ADC/SBB sequences.
//
// Optional feature: define ALU_MUL_EN to compile in the iterative shift-add multiplier
// (opcode C, WIDTH cycles, MUL_BUSY state). Without it, opcode C is illegal.
//
// Parameters
//   WIDTH      datapath width (>= 4, multiple of BLOCK)
//   BLOCK      carry-select adder block size
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operation presented
//   in_ready   operation accepted this cycle when in_valid is also high
//   A, B       operands; shift amount is B[$clog2(WIDTH)-1:0]
//   opcode     operation select
//   out_valid  result/flags valid
//   out_ready  consumer takes the result
//   result     registered result
//   Cout, Zero, Neg, Ovf, Err  registered flags
module alu_pipe_param #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             Cout,
   output logic             Zero,
   output logic             Neg,
   output logic             Ovf,
   output logic             Err
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned NB = WIDTH / BLOCK;

   localparam logic [3:0] OpAdd = 4'h0;
   localparam logic [3:0] OpSub = 4'h1;
   localparam logic [3:0] OpOr  = 4'h2;
   localparam logic [3:0] OpAnd = 4'h3;
   localparam logic [3:0] OpXor = 4'h4;
   localparam logic [3:0] OpNot = 4'h5;
   localparam logic [3:0] OpShl = 4'h6;
   localparam logic [3:0] OpShr = 4'h7;
   localparam logic [3:0] OpAdc = 4'h8;
   localparam logic [3:0] OpSbb = 4'h9;
   localparam logic [3:0] OpSar = 4'hA;
   localparam logic [3:0] OpRol = 4'hB;
`ifdef ALU_MUL_EN
   localparam logic [3:0] OpMul = 4'hC;
`endif

   typedef enum logic [0:0] {StIdle, StMulBusy} state_t;

   state_t state;
   logic   c_flag;
   logic   accept;

   assign in_ready = rst_n && (state == StIdle) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // ---------------------------------------------------------------- adder operand select
   logic [WIDTH-1:0] add_b;
   logic             add_cin;

   always_comb begin
      add_b   = B;
      add_cin = 1'b0;
      case (opcode)
         OpSub: begin
            add_b   = ~B;
            add_cin = 1'b1;
         end
         OpAdc: add_cin = c_flag;
         OpSbb: begin
            add_b   = ~B;
            add_cin = c_flag;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- carry-select adder
   // Each block computes both carry-in cases up front; only the select mux sits on the
   // block-to-block carry path.
   logic [WIDTH-1:0] add_sum;
   logic [NB:0]      blk_c;
   logic [BLOCK:0]   blk0;
   logic [BLOCK:0]   blk1;
   logic             add_cout;
   logic             add_ovf;

   always_comb begin
      add_sum  = '0;
      blk_c    = '0;
      blk0     = '0;
      blk1     = '0;
      blk_c[0] = add_cin;
      for (int i = 0; i < int'(NB); i++) begin
         blk0 = {1'b0, A[i*BLOCK +: BLOCK]} + {1'b0, add_b[i*BLOCK +: BLOCK]};
         blk1 = {1'b0, A[i*BLOCK +: BLOCK]} + {1'b0, add_b[i*BLOCK +: BLOCK]}
                + {{BLOCK{1'b0}}, 1'b1};
         add_sum[i*BLOCK +: BLOCK] = blk_c[i] ? blk1[BLOCK-1:0] : blk0[BLOCK-1:0];
         blk_c[i+1]                = blk_c[i] ? blk1[BLOCK] : blk0[BLOCK];
      end
   end

   assign add_cout = blk_c[NB];
   assign add_ovf  = (A[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);

   // ---------------------------------------------------------------- shifter
   // Shifts carry one extra bit so the last bit shifted out falls out naturally and is
   // 0 for a zero shift amount.
   logic [SW-1:0]      shamt;
   logic [SW-1:0]      rot_amt;
   logic [WIDTH:0]     shl_w;
   logic [WIDTH:0]     shr_w;
   logic [WIDTH:0]     sar_w;
   logic [2*WIDTH-1:0] rol_w;

   assign shamt   = B[SW-1:0];
   assign rot_amt = SW'(32'(shamt) % WIDTH);
   assign shl_w   = {1'b0, A} << shamt;
   assign shr_w   = {A, 1'b0} >> shamt;
   assign sar_w   = $signed({A, 1'b0}) >>> shamt;
   assign rol_w   = {A, A} << rot_amt;

   // ---------------------------------------------------------------- result select
   logic [WIDTH-1:0] nx_res;
   logic             nx_cout;
   logic             nx_ovf;
   logic             nx_err;
   logic             nx_ld_c;
   logic             is_mul;

   always_comb begin
      nx_res  = '0;
      nx_cout = 1'b0;
      nx_ovf  = 1'b0;
      nx_err  = 1'b0;
      nx_ld_c = 1'b0;
      is_mul  = 1'b0;
      case (opcode)
         OpAdd, OpSub, OpAdc, OpSbb: begin
            nx_res  = add_sum;
            nx_cout = add_cout;
            nx_ovf  = add_ovf;
            nx_ld_c = 1'b1;
         end
         OpOr:  nx_res = A | B;
         OpAnd: nx_res = A & B;
         OpXor: nx_res = A ^ B;
         OpNot: nx_res = ~A;
         OpShl: begin
            nx_res  = shl_w[WIDTH-1:0];
            nx_cout = shl_w[WIDTH];
         end
         OpShr: begin
            nx_res  = shr_w[WIDTH:1];
            nx_cout = shr_w[0];
         end
         OpSar: begin
            nx_res  = sar_w[WIDTH:1];
            nx_cout = sar_w[0];
         end
         OpRol: begin
            nx_res  = rol_w[2*WIDTH-1:WIDTH];
            // Last bit rotated out of the MSB ends up in bit 0.
            nx_cout = (shamt != '0) ? rol_w[WIDTH] : 1'b0;
         end
`ifdef ALU_MUL_EN
         OpMul: is_mul = 1'b1;
`endif
         default: nx_err = 1'b1;
      endcase
   end

`ifdef ALU_MUL_EN
   // ---------------------------------------------------------------- shift-add multiplier
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic [WIDTH-1:0] mul_acc;
   logic [WIDTH-1:0] mul_sum;
   logic [SW-1:0]    cnt;

   assign mul_sum = mul_acc + (mul_b[0] ? mul_a : '0);
`endif

   // ---------------------------------------------------------------- state, carry, output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         c_flag    <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         Cout      <= 1'b0;
         Zero      <= 1'b0;
         Neg       <= 1'b0;
         Ovf       <= 1'b0;
         Err       <= 1'b0;
`ifdef ALU_MUL_EN
         cnt       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_acc   <= '0;
`endif
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            StIdle: begin
`ifdef ALU_MUL_EN
               if (accept && is_mul) begin
                  state   <= StMulBusy;
                  mul_a   <= A;
                  mul_b   <= B;
                  mul_acc <= '0;
                  cnt     <= '0;
               end
`endif
               if (accept && !is_mul) begin
                  out_valid <= 1'b1;
                  result    <= nx_res;
                  Cout      <= nx_cout;
                  Zero      <= (nx_res == '0);
                  Neg       <= nx_res[WIDTH-1];
                  Ovf       <= nx_ovf;
                  Err       <= nx_err;
                  if (nx_ld_c) begin
                     c_flag <= nx_cout;
                  end
               end
            end
`ifdef ALU_MUL_EN
            StMulBusy: begin
               mul_acc <= mul_sum;
               mul_a   <= mul_a << 1;
               mul_b   <= mul_b >> 1;
               cnt     <= cnt + SW'(1);
               // Output is free here: accepting the MUL required it to drain first.
               if (cnt == SW'(WIDTH - 1)) begin
                  state     <= StIdle;
                  cnt       <= '0;
                  out_valid <= 1'b1;
                  result    <= mul_sum;
                  Cout      <= 1'b0;
                  Zero      <= (mul_sum == '0);
                  Neg       <= mul_sum[WIDTH-1];
                  Ovf       <= 1'b0;
                  Err       <= 1'b0;
               end
            end
`endif
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/alu_pipe_param.md
# alu_pipe_param

Parametrised, handshaked successor to the team's fixed 16-bit registered ALU. Supports configurable datapath width, a carry-select adder with configurable block size, a persistent carry flag for multi-word ADC/SBB chains, and barrel shifts/rotates. An optional iterative shift-add multiplier can be compiled in. Sits between the operand-fetch stage and the writeback register file, using valid/ready on both sides.

## Interface
- WIDTH, 16: datapath width; ≥4, multiple of BLOCK.
- BLOCK, 4: CSLA block size in bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- A, B  in  WIDTH  operands; shift amount = B[$clog2(WIDTH)-1:0].
- opcode  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- Cout, Zero, Neg, Ovf, Err  out  1 each  registered flags.

## Operation
- Opcodes:
  - 0 ADD; 1 SUB (A+~B+1); 2 OR; 3 AND; 4 XOR; 5 NOT A.
  - 6 SHL; 7 SHR (logical); 8 ADC (A+B+C); 9 SBB (A+~B+C).
  - A SAR; B ROL (rotate left by the shift amount); C MUL (low WIDTH bits of A*B, unsigned); D–F illegal.
- Adder: all add-type ops use one CSLA with WIDTH/BLOCK blocks. Carry chains through block muxes; no ripple across blocks.
- C: internal carry register.
  - Loaded with Cout whenever an ADD/SUB/ADC/SBB result is registered.
  - Other ops leave C unchanged.
  - SUB/SBB carry convention: 1 = no borrow (A ≥ B unsigned for SUB).
- Flags on every registered result:
  - Zero = (result == 0).
  - Neg = result[WIDTH-1].
  - Ovf = signed overflow for add-type ops, else 0.
  - Cout: add-type ops use the adder carry-out. Shifts/rotates use the last bit shifted out (0 when amount = 0). Logic ops and MUL give 0.
  - Err = 1 only for illegal opcodes.
- Illegal opcode: result = 0, Err = 1, Zero = 1, other flags 0, C unchanged.
- States: IDLE, MUL_BUSY.
  - IDLE → MUL_BUSY on MUL accept.
  - MUL_BUSY runs a WIDTH-step counter, then loads the output register and returns to IDLE.

## Timing
- Accept = in_valid && in_ready.
- in_ready = rst_n && state == IDLE && (!out_valid || out_ready).
- Non-MUL ops: result and flags registered at the accept edge; out_valid is high the following cycle (latency 1). Full throughput while out_ready = 1.
- ADC/SBB accepted the cycle after an add-type op use that op's C (C is registered at the same edge as the result).
- MUL accepted at edge t: out_valid rises at edge t+WIDTH. in_ready stays 0 for all of MUL_BUSY.
- The output register is a one-entry buffer: result and flags hold stable while out_valid && !out_ready.
- out_valid clears at the edge where out_ready = 1, unless a new accept reloads it at the same edge.
- Reset (rst_n low at an edge), including mid-MUL:
  - state IDLE, counter 0, C = 0.
  - out_valid = 0, result = 0, all flags = 0.
  - in_ready = 0 while rst_n is low.

## Configuration
- ALU_MUL_EN defined: MUL datapath, counter and MUL_BUSY state are compiled in.
- ALU_MUL_EN undefined: opcode C is treated as illegal (1-cycle, result 0, Err = 1), and the state machine is permanently IDLE.

## Test plan
- ADD 0xFFFF + 0x0001, out_ready = 1 → next cycle result 0x0000, Cout = 1, Zero = 1, Ovf = 0, Neg = 0.
- SUB 0x8000 − 0x0001 → 0x7FFF, Cout = 1, Ovf = 1. Then SUB 0x0001 − 0x0002 → 0xFFFF, Cout = 0, Neg = 1.
- Carry chain: ADD 0xFFFF + 0x0001, then ADC 0x0000 + 0x0000 on the next cycle → second result 0x0001. Repeat the pair with reset asserted between them → 0x0000.
- Backpressure: hold out_ready = 0 after XOR 0x00FF ^ 0x0F0F → result 0x0FF0 held, in_ready = 0, a pending in_valid is not accepted. Then raise out_ready with a new op presented → it is accepted at the same edge.
- MUL (ALU_MUL_EN defined) 0x0012 × 0x0034 → 0x03A8, out_valid exactly 16 cycles after accept, in_ready = 0 throughout. Repeat with rst_n low at cycle 8 → out_valid never asserts, in_ready = 1 after release.
- SAR 0x8001 by 1 → 0xC000, Cout = 1. ROL 0x8001 by 4 → 0x0018. Opcode 0xD → result 0, Err = 1, Zero = 1.
